// File: rtl/uart_tx_sequencer_if.sv
// rtl/uart_tx_sequencer_if.sv - byte handshake between a byte source and the UART TX sequencer
interface uart_tx_sequencer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_sequencer.sv
// rtl/uart_tx_sequencer.sv - UART TX bit sequencer: start, 8 data bits LSB first, stop, CLKS_PER_BIT clocks each
module uart_tx_sequencer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                 clock,
    input  logic                 reset,
    uart_tx_sequencer_if.slave   s_tx,
    output logic                 tx,
    output logic                 busy,
    output logic                 bit_tick
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;
    logic           ready_q;
    logic           period_end;

    assign period_end = (state_q != IDLE) && (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = 1'b1;

        if (state_q != IDLE) begin
            cnt_d = period_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (s_tx.tx_valid && ready_q) begin
                    shift_d = s_tx.tx_data;
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = START;
                end
            end
            START: begin
                if (period_end) begin
                    idx_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (period_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (period_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // tx is registered from the next-state view so the line changes on the same edge as the state
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ready_q <= (state_d == IDLE);
        end
    end

    assign tx             = tx_q;
    assign busy           = ~ready_q;
    assign bit_tick       = period_end;
    assign s_tx.tx_ready  = ready_q;
endmodule
